// File: rtl/link_rx.sv
`default_nettype none
// ============================================================================
//  Module   : link_rx
//  Purpose  : Receive-side conditioner for the board-to-board game link.
//             Synchronises the asynchronous peer ready/hit/coordinate pins
//             into control_clk, deglitches them with a stability counter,
//             and presents main_fsm with a clean ready level, latched
//             hit/coordinates, a capture strobe and a protocol-error strobe.
//  Revision : 1.0  initial release
// ============================================================================
module link_rx #(
  parameter int DATA_WIDTH    = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready_in,
  input  logic                  hit_in,
  input  logic [DATA_WIDTH-1:0] cords_in,
  output logic                  ready_out,
  output logic                  hit_out,
  output logic [DATA_WIDTH-1:0] cords_out,
  output logic                  cords_valid,
  output logic                  link_err
);

  // Word layout: {ready, hit, cords}
  localparam int              WORD_W    = DATA_WIDTH + 2;
  localparam int              READY_BIT = WORD_W - 1;
  localparam int              HIT_BIT   = WORD_W - 2;
  localparam int              CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Synchroniser stages and the one-cycle-delayed copy used for change detect
  logic [WORD_W-1:0]     sync1_q;
  logic [WORD_W-1:0]     sync2_q;
  logic [WORD_W-1:0]     sync2_dly_q;
  logic [CNT_W-1:0]      stab_cnt_q, stab_cnt_d;
  state_t                state_q, state_d;
  logic                  err_done_q, err_done_d;
  logic                  ready_q, ready_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] cords_q, cords_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  w_word_change;
  logic                  w_stable;
  logic                  w_s_ready;
  logic                  w_s_hit;
  logic [DATA_WIDTH-1:0] w_s_cords;
  logic                  w_differs;

  assign w_word_change = (sync2_q != sync2_dly_q);
  assign w_stable      = (stab_cnt_q == CNT_MAX);

  // When the counter is saturated the delayed copy has been equal to the
  // live word for the whole window, so it is the accepted value. Taking it
  // from the delayed copy means a change landing in the very capture cycle
  // can never sneak an unfiltered word through.
  assign w_s_ready = sync2_dly_q[READY_BIT];
  assign w_s_hit   = sync2_dly_q[HIT_BIT];
  assign w_s_cords = sync2_dly_q[DATA_WIDTH-1:0];
  assign w_differs = ({w_s_hit, w_s_cords} != {hit_q, cords_q});

  // Stability counter: clear on any word change, else count up and saturate
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (w_word_change) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != CNT_MAX) begin
      stab_cnt_d = stab_cnt_q + CNT_ONE;
    end
  end

  // Transaction FSM next-state and registered-output next values
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    hit_d      = hit_q;
    cords_d    = cords_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    err_done_d = err_done_q;

    if (w_stable) begin
      ready_d = w_s_ready;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_stable && w_s_ready) begin
          hit_d   = w_s_hit;
          cords_d = w_s_cords;
          valid_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_stable) begin
          if (!w_s_ready) begin
            state_d = ST_IDLE;
          end else if (w_differs && !err_done_q) begin
            // Peer changed its word without dropping ready: flag it once
            // and track the new value so main_fsm sees what the peer holds.
            err_d      = 1'b1;
            hit_d      = w_s_hit;
            cords_d    = w_s_cords;
            err_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The one-shot re-arms whenever the counter restarts on a new word
    if (w_word_change) begin
      err_done_d = 1'b0;
    end
  end

  // All state registers, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync2_dly_q <= '0;
      stab_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      err_done_q  <= 1'b0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      cords_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= {ready_in, hit_in, cords_in};
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      stab_cnt_q  <= stab_cnt_d;
      state_q     <= state_d;
      err_done_q  <= err_done_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      cords_q     <= cords_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign ready_out   = ready_q;
  assign hit_out     = hit_q;
  assign cords_out   = cords_q;
  assign cords_valid = valid_q;
  assign link_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_link_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_link_rx
//  Purpose  : Directed self-checking bench for link_rx (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_link_rx;

  localparam int DATA_WIDTH = 8;
  localparam int LAT        = 19;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ready_in;
  logic                  hit_in;
  logic [DATA_WIDTH-1:0] cords_in;
  logic                  ready_out;
  logic                  hit_out;
  logic [DATA_WIDTH-1:0] cords_out;
  logic                  cords_valid;
  logic                  link_err;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_overlap = 0;

  link_rx #(.DATA_WIDTH(DATA_WIDTH), .STABLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready_in   (ready_in),
    .hit_in     (hit_in),
    .cords_in   (cords_in),
    .ready_out  (ready_out),
    .hit_out    (hit_out),
    .cords_out  (cords_out),
    .cords_valid(cords_valid),
    .link_err   (link_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance n edges, sampling 1ns after each. Index k=0 is the first edge
  // after the call (edge E0 for inputs driven just before the call).
  task automatic run(input int n, output int cv_n, output int er_n,
                     output int first_cv, output int first_er, output int rdy_chg);
    logic r0;
    r0 = ready_out;
    cv_n = 0; er_n = 0; first_cv = -1; first_er = -1; rdy_chg = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (cords_valid === 1'b1) begin
        if (first_cv < 0) first_cv = k;
        cv_n++;
      end
      if (link_err === 1'b1) begin
        if (first_er < 0) first_er = k;
        er_n++;
      end
      if (cords_valid === 1'b1 && link_err === 1'b1) n_overlap++;
      if (rdy_chg < 0 && ready_out !== r0) rdy_chg = k;
    end
  endtask

  initial begin
    int cv, er, fcv, fer, rc;
    int tot_cv, tot_er;

    rst = 1'b0; ready_in = 1'b0; hit_in = 1'b0; cords_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset ready_out",   int'(ready_out),   0);
    check_eq("reset hit_out",     int'(hit_out),     0);
    check_eq("reset cords_out",   int'(cords_out),   0);
    check_eq("reset cords_valid", int'(cords_valid), 0);
    check_eq("reset link_err",    int'(link_err),    0);
    rst = 1'b1;
    run(25, cv, er, fcv, fer, rc);
    check_eq("idle no valid", cv, 0);

    // Glitch reject: 10-cycle ready pulse
    ready_in = 1'b1;
    run(10, cv, er, fcv, fer, rc);
    ready_in = 1'b0;
    run(40, tot_cv, tot_er, fcv, fer, rc);
    check_eq("glitch valid count", cv + tot_cv, 0);
    check_eq("glitch ready_out",   int'(ready_out), 0);

    // Basic capture
    ready_in = 1'b1; hit_in = 1'b1; cords_in = 8'h35;
    run(40, cv, er, fcv, fer, rc);
    check_eq("cap1 valid count",   cv, 1);
    check_eq("cap1 valid latency", fcv, LAT);
    check_eq("cap1 ready latency", rc, LAT);
    check_eq("cap1 cords_out",     int'(cords_out), 'h35);
    check_eq("cap1 hit_out",       int'(hit_out), 1);
    check_eq("cap1 ready_out",     int'(ready_out), 1);
    check_eq("cap1 no err",        er, 0);

    // Protocol error: cords change while ready held
    cords_in = 8'h36;
    run(40, cv, er, fcv, fer, rc);
    check_eq("err count",     er, 1);
    check_eq("err latency",   fer, LAT);
    check_eq("err no valid",  cv, 0);
    check_eq("err cords_out", int'(cords_out), 'h36);
    check_eq("err hit_out",   int'(hit_out), 1);

    // Release, then second transaction
    ready_in = 1'b0;
    run(30, cv, er, fcv, fer, rc);
    check_eq("rel ready latency", rc, LAT);
    check_eq("rel ready_out",     int'(ready_out), 0);
    check_eq("rel no valid",      cv, 0);
    ready_in = 1'b1; hit_in = 1'b0; cords_in = 8'hB0;
    run(40, cv, er, fcv, fer, rc);
    check_eq("cap2 valid count",   cv, 1);
    check_eq("cap2 valid latency", fcv, LAT);
    check_eq("cap2 cords_out",     int'(cords_out), 'hB0);
    check_eq("cap2 hit_out",       int'(hit_out), 0);
    check_eq("cap2 no err",        er, 0);

    // Chatter: cords toggle every 5 cycles for 200 cycles, ending on 0xB0
    tot_cv = 0; tot_er = 0;
    for (int i = 0; i < 40; i++) begin
      cords_in = (i % 2 == 0) ? 8'hB1 : 8'hB0;
      run(5, cv, er, fcv, fer, rc);
      tot_cv += cv; tot_er += er;
    end
    run(30, cv, er, fcv, fer, rc);
    tot_cv += cv; tot_er += er;
    check_eq("chatter no valid",  tot_cv, 0);
    check_eq("chatter no err",    tot_er, 0);
    check_eq("chatter cords_out", int'(cords_out), 'hB0);
    check_eq("chatter ready_out", int'(ready_out), 1);

    // Reset mid-transaction
    ready_in = 1'b0;
    run(30, cv, er, fcv, fer, rc);
    check_eq("pre-rst ready_out", int'(ready_out), 0);
    ready_in = 1'b1; hit_in = 1'b1; cords_in = 8'h5A;
    run(10, cv, er, fcv, fer, rc);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("mid-rst ready_out",   int'(ready_out),   0);
    check_eq("mid-rst hit_out",     int'(hit_out),     0);
    check_eq("mid-rst cords_out",   int'(cords_out),   0);
    check_eq("mid-rst cords_valid", int'(cords_valid), 0);
    check_eq("mid-rst link_err",    int'(link_err),    0);
    run(40, cv, er, fcv, fer, rc);
    check_eq("post-rst valid count",   cv, 1);
    check_eq("post-rst valid latency", fcv, LAT);
    check_eq("post-rst cords_out",     int'(cords_out), 'h5A);
    check_eq("post-rst hit_out",       int'(hit_out), 1);

    check_eq("valid/err overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_rx.md
# link_rx

Receive-side conditioner for the board-to-board game link. It takes the raw `ready2`, `hit2` and `ship_cords_in` pins from the peer FPGA, which are asynchronous to `control_clk`. It synchronises and deglitches them, then hands `main_fsm` a clean `ready` level, a latched hit flag and latched coordinates, plus a one-cycle `cords_valid` strobe per peer transaction. It sits between the top-level pins and the `ready2` / `hit2` / `ship_cords_in` inputs of `main_fsm`, in the `control_clk` domain.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: coordinate bus width, packed as {y[3:0], x[3:0]}.
- `STABLE_CYCLES`, default 16: consecutive unchanged synchronised samples needed before a value is accepted. Must be ≥ 2.

Ports:
- `clk` in 1: `control_clk` domain. Single clock.
- `rst` in 1: reset, synchronous, active-low.
- `ready_in` in 1: raw peer ready (async).
- `hit_in` in 1: raw peer hit (async).
- `cords_in` in DATA_WIDTH: raw peer coordinates (async).
- `ready_out` out 1: filtered ready level, to `main_fsm.ready2`.
- `hit_out` out 1: hit flag latched at the last capture.
- `cords_out` out DATA_WIDTH: coordinates latched at the last capture.
- `cords_valid` out 1: one-cycle pulse when a new transaction is captured.
- `link_err` out 1: one-cycle pulse on a protocol violation.

## Operation
- **Synchronisation:** all DATA_WIDTH+2 inputs pass through a 2-flop synchroniser (`s1` → `s2`) as one word w = {ready, hit, cords}.
- **Stability counter:** `stab_cnt`, width $clog2(STABLE_CYCLES+1).
  - Cleared to 0 in any cycle where `s2` ≠ `s2_q` (`s2_q` is `s2` delayed one cycle).
  - Otherwise increments, saturating at STABLE_CYCLES.
  - `stable` = (`stab_cnt` == STABLE_CYCLES).
- **Filtered ready:** `ready_out` updates to `s2.ready` only when `stable`; otherwise it holds.
- **FSM states:**
  - IDLE
    - `stable` && `s2.ready`=1 → latch `cords_out` ← `s2.cords` and `hit_out` ← `s2.hit`; pulse `cords_valid` for 1 cycle; go to BUSY.
    - Anything else → stay in IDLE.
  - BUSY (peer is holding ready high)
    - `stable` && `s2.ready`=0 → IDLE. No capture.
    - `stable` && `s2.ready`=1 && {`s2.hit`, `s2.cords`} ≠ {`hit_out`, `cords_out`} → pulse `link_err`; re-latch the new values; no `cords_valid`; stay in BUSY.
    - Anything else → stay in BUSY.
  - `link_err` fires at most once per distinct stable value. It is gated by a one-shot flag that clears on the next counter reset.
- **Unstable input:** a word that toggles more often than every STABLE_CYCLES samples is never accepted. Outputs hold their last values indefinitely.
- **Reset:** when `rst`=0 at a clock edge, all state returns to reset values on that edge, even mid-transaction.
  - FSM → IDLE; `s1`, `s2`, `s2_q` → 0; `stab_cnt` → 0.
  - `ready_out`, `hit_out`, `cords_valid`, `link_err` → 0; `cords_out` → 0.
  - A ready already high at reset release is captured normally after the stability window. It is not lost.

## Timing
- All outputs are registered.
- **Capture latency:** inputs change before edge E0 and then stay constant.
  - `s2` takes the new value after E1.
  - `stab_cnt` clears at E2, then counts one per edge and reaches STABLE_CYCLES at E(STABLE_CYCLES+2).
  - `cords_valid`, `cords_out` and `ready_out` update at E(STABLE_CYCLES+3).
  - Latency = STABLE_CYCLES+3 cycles; 19 at the default.
- **Release latency:** ready falling to `ready_out`=0 also takes STABLE_CYCLES+3 cycles.
- **Throughput:** minimum full transaction (rise, hold, fall) is 2·(STABLE_CYCLES+3) cycles.
- **Pulse width:** `cords_valid` and `link_err` are exactly 1 cycle wide and never asserted in the same cycle.
- **Same-edge changes:** cords and ready changing on the same edge are one word change; a single capture with the new cords results.

## Test plan
1. **Basic capture:** reset, then `ready_in`=1, `hit_in`=1, `cords_in`=0x35 held. → Exactly 1 `cords_valid` pulse at cycle 19 after the input edge; `cords_out`=0x35; `hit_out`=1; `ready_out`=1.
2. **Glitch reject:** `ready_in` pulses high for 10 cycles, then low. → No `cords_valid`; `ready_out` stays 0.
3. **Release and second transaction:** after scenario 1, drop ready for 30 cycles, then raise it with `cords_in`=0xB0, `hit_in`=0. → `ready_out` falls 19 cycles after the drop; second `cords_valid` with `cords_out`=0xB0, `hit_out`=0.
4. **Protocol error:** in BUSY, change `cords_in` 0x35 → 0x36 while ready stays high. → Exactly 1 `link_err` pulse 19 cycles after the change; `cords_out`=0x36; no `cords_valid`.
5. **Reset mid-transaction:** assert `rst`=0 for 1 cycle at cycle 10 of a capture window. → All outputs 0 on the next edge; with inputs still held, capture occurs 19 cycles after reset release.
6. **Chatter:** `cords_in` toggles every 5 cycles for 200 cycles with ready high. → No `cords_valid`, no `link_err`, outputs hold.
